// File: rtl/traffic_sequencer_if.sv
// traffic_sequencer_pkg / traffic_sequencer_if
//
// The package holds the phase encoding and lamp codes shared by the
// sequencer and anything that needs to name a phase.
//
// The interface bundles the sequencer's timer link, lamp drives and
// pedestrian inputs. Clock and reset stay plain ports on the module.
//   trigger     timer -> seq  one-cycle phase-expired pulse
//   ped_req     env   -> seq  pedestrian button, level or pulse
//   hold        env   -> seq  1 freezes the current phase
//   tmr_ref     seq   -> timer dwell reference (7 bits, registered)
//   tmr_clear   seq   -> timer one-cycle restart strobe
//   ns_light    seq   -> lamp  north-south lamp (00 red, 01 green, 10 yellow)
//   ew_light    seq   -> lamp  east-west lamp, same encoding
//   walk        seq   -> lamp  pedestrian walk lamp
//   phase       seq   -> debug current state code
//   ped_pending seq   -> debug latched pedestrian request
//
// Timer handshake: tmr_clear is high for exactly the first cycle of every
// phase; the timer restarts from zero when it sees it. trigger is only
// honoured on a cycle where tmr_clear is low and hold is low; a trigger
// that coincides with tmr_clear is treated as a stale pulse left over from
// the previous phase and is dropped. There is no back-pressure beyond that.
//
// The dwell reference is called tmr_ref because "ref" is a reserved word.

package traffic_sequencer_pkg;

    typedef enum logic [2:0] {
        NS_G   = 3'd0,
        NS_Y   = 3'd1,
        RED_A  = 3'd2,
        EW_G   = 3'd3,
        EW_Y   = 3'd4,
        RED_B  = 3'd5,
        PED    = 3'd6,
        ST_BAD = 3'd7
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;

endpackage

interface traffic_sequencer_if;

    logic       trigger;
    logic       ped_req;
    logic       hold;
    logic [6:0] tmr_ref;
    logic       tmr_clear;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       walk;
    logic [2:0] phase;
    logic       ped_pending;

    // Sequencer side.
    modport master (
        input  trigger, ped_req, hold,
        output tmr_ref, tmr_clear, ns_light, ew_light, walk, phase, ped_pending
    );

    // Timer / lamp / environment side.
    modport slave (
        output trigger, ped_req, hold,
        input  tmr_ref, tmr_clear, ns_light, ew_light, walk, phase, ped_pending
    );

endinterface

// File: rtl/traffic_sequencer.sv
// traffic_sequencer
//
// Phase sequencer for a two-way intersection with a pedestrian crossing.
// Cycles NS green/yellow, all-red, EW green/yellow, all-red, inserting a
// pedestrian walk phase after an all-red when a request is pending. Each
// phase's dwell is measured by an external timer that this block restarts
// on every phase entry and whose expiry pulse advances the state.
//
// Ports:
//   clock  system clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    traffic_sequencer_if.master (timer link, lamps, walk, debug)
//
// Parameters: G_TIME, Y_TIME, R_TIME, P_TIME are the dwell references
// sent to the timer for green, yellow, all-red and walk phases.

module traffic_sequencer
    import traffic_sequencer_pkg::*;
#(
    parameter logic [6:0] G_TIME = 7'd59,
    parameter logic [6:0] Y_TIME = 7'd9,
    parameter logic [6:0] R_TIME = 7'd1,
    parameter logic [6:0] P_TIME = 7'd29
) (
    input  logic                  clock,
    input  logic                  reset,
    traffic_sequencer_if.master   bus
);

    // Registered state and outputs.
    state_t     state;
    state_t     next_dir;
    logic       ped_pending;
    logic       clear_q;
    logic [6:0] ref_q;
    logic [1:0] ns_q;
    logic [1:0] ew_q;
    logic       walk_q;

    // Next-cycle values.
    state_t     state_d;
    state_t     next_dir_d;
    logic       ped_pending_d;
    logic       advance;
    logic       enter;
    logic [6:0] ref_d;
    logic [1:0] ns_d;
    logic [1:0] ew_d;
    logic       walk_d;

    always_comb begin
        // A trigger during the entry cycle belongs to the previous phase.
        advance    = bus.trigger && !clear_q && !bus.hold;
        state_d    = state;
        next_dir_d = next_dir;

        case (state)
            NS_G:  if (advance) state_d = NS_Y;
            NS_Y:  if (advance) state_d = RED_A;
            RED_A: if (advance) begin
                       state_d    = ped_pending ? PED : EW_G;
                       next_dir_d = EW_G;
                   end
            EW_G:  if (advance) state_d = EW_Y;
            EW_Y:  if (advance) state_d = RED_B;
            RED_B: if (advance) begin
                       state_d    = ped_pending ? PED : NS_G;
                       next_dir_d = NS_G;
                   end
            PED:   if (advance) state_d = next_dir;
            default: state_d = NS_G;  // illegal code recovers unconditionally
        endcase

        // No transition returns to its own state, so any change is an entry.
        enter = (state_d != state);

        // Entering PED consumes the request and beats a simultaneous press;
        // presses during PED are not latched.
        ped_pending_d = ped_pending;
        if (enter && state_d == PED) begin
            ped_pending_d = 1'b0;
        end else if (bus.ped_req && state != PED) begin
            ped_pending_d = 1'b1;
        end

        // Outputs are decoded from the next state so they change on the
        // same edge as the state register.
        ns_d   = LAMP_RED;
        ew_d   = LAMP_RED;
        walk_d = 1'b0;
        ref_d  = G_TIME;
        case (state_d)
            NS_G: begin ns_d = LAMP_GREEN;  ref_d = G_TIME; end
            NS_Y: begin ns_d = LAMP_YELLOW; ref_d = Y_TIME; end
            EW_G: begin ew_d = LAMP_GREEN;  ref_d = G_TIME; end
            EW_Y: begin ew_d = LAMP_YELLOW; ref_d = Y_TIME; end
            RED_A, RED_B: ref_d = R_TIME;
            PED:  begin walk_d = 1'b1; ref_d = P_TIME; end
            default: ref_d = G_TIME;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= NS_G;
            next_dir    <= EW_G;
            ped_pending <= 1'b0;
            clear_q     <= 1'b1;
            ref_q       <= G_TIME;
            ns_q        <= LAMP_GREEN;
            ew_q        <= LAMP_RED;
            walk_q      <= 1'b0;
        end else begin
            state       <= state_d;
            next_dir    <= next_dir_d;
            ped_pending <= ped_pending_d;
            clear_q     <= enter;
            ref_q       <= ref_d;
            ns_q        <= ns_d;
            ew_q        <= ew_d;
            walk_q      <= walk_d;
        end
    end

    assign bus.tmr_ref     = ref_q;
    assign bus.tmr_clear   = clear_q;
    assign bus.ns_light    = ns_q;
    assign bus.ew_light    = ew_q;
    assign bus.walk        = walk_q;
    assign bus.phase       = state;
    assign bus.ped_pending = ped_pending;

    // Conflicting greens/yellows are a design error, never a legal state.
    a_no_conflict : assert property (@(posedge clock) disable iff (reset)
        !(ns_q != LAMP_RED && ew_q != LAMP_RED));

endmodule

// File: tb/tb_traffic_sequencer.sv
// tb_traffic_sequencer
//
// Table-driven vectors for single-edge behaviour, followed by hand-written
// sequences against a model phase timer for dwell lengths, pedestrian
// service, hold, reset and illegal-state recovery.

module tb_traffic_sequencer;
    import traffic_sequencer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    traffic_sequencer_if bus ();

    traffic_sequencer dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // ---------------- model timer ----------------
    // Restarts on tmr_clear; fires while the count equals the reference,
    // which gives ref+2 cycles per phase from entry edge to exit edge.
    logic       timer_en = 1'b0;
    logic       man_trig = 1'b0;
    logic [7:0] cnt = 8'd0;

    always @(posedge clk) begin
        if (bus.tmr_clear) cnt <= 8'd0;
        else               cnt <= cnt + 8'd1;
    end

    assign bus.trigger = timer_en ? (cnt == {1'b0, bus.tmr_ref}) : man_trig;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_of(input logic [2:0] ph);
        case (ph)
            3'd0, 3'd3: return 59;
            3'd1, 3'd4: return 9;
            3'd2, 3'd5: return 1;
            3'd6:       return 29;
            default:    return 59;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ped_req = 1'b0;
        bus.hold = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Waits for the phase to change, then checks the newly entered phase.
    // dur is the number of samples spent in the phase being left, counted
    // from the sample this task was called at.
    task automatic wait_change(input logic [2:0] exp_ph, output int dur);
        logic [2:0] cur;
        int n;
        int extra_clr;
        cur = bus.phase;
        n = 1;
        extra_clr = 0;
        step();
        while (bus.phase == cur && n < 300) begin
            if (bus.tmr_clear) extra_clr++;
            n++;
            step();
        end
        check("phase_change_in_time", int'(n < 300), 1);
        check("single_clear_pulse", extra_clr, 0);
        check("entered_phase", bus.phase, exp_ph);
        check("entry_ref", bus.tmr_ref, ref_of(exp_ph));
        check("entry_clear", bus.tmr_clear, 1);
        dur = n;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       trig;
        logic       req;
        logic       hold;
        logic [2:0] ph;
        logic [6:0] rf;
        logic       clr;
        logic [1:0] ns;
        logic [1:0] ew;
        logic       walk;
        logic       pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic t, input logic q, input logic h,
                       input logic [2:0] ph, input logic [6:0] rf, input logic c,
                       input logic [1:0] ns, input logic [1:0] ew,
                       input logic w, input logic p);
        vec_t v;
        v.rst = r; v.trig = t; v.req = q; v.hold = h;
        v.ph = ph; v.rf = rf; v.clr = c; v.ns = ns; v.ew = ew;
        v.walk = w; v.pend = p;
        vecs.push_back(v);
    endtask

    // Watchdog: the bench must always end.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dur;
        int bad;
        logic [2:0] prev;
        logic [2:0] ph;
        logic first;

        bus.ped_req = 1'b0;
        bus.hold = 1'b0;

        //    rst trg req hld  ph   ref clr ns     ew     wlk pend
        add(1, 0, 0, 0, 3'd0, 59, 1, 2'b01, 2'b00, 0, 0);  // reset state
        add(0, 1, 0, 0, 3'd0, 59, 0, 2'b01, 2'b00, 0, 0);  // stale trigger dropped
        add(0, 1, 0, 0, 3'd1, 9,  1, 2'b10, 2'b00, 0, 0);  // NS_G -> NS_Y
        add(0, 1, 0, 0, 3'd1, 9,  0, 2'b10, 2'b00, 0, 0);  // entry-cycle trigger dropped
        add(0, 1, 0, 0, 3'd2, 1,  1, 2'b00, 2'b00, 0, 0);  // NS_Y -> RED_A
        add(0, 0, 0, 0, 3'd2, 1,  0, 2'b00, 2'b00, 0, 0);
        add(0, 1, 0, 0, 3'd3, 59, 1, 2'b00, 2'b01, 0, 0);  // RED_A -> EW_G
        add(0, 0, 1, 0, 3'd3, 59, 0, 2'b00, 2'b01, 0, 1);  // request latched
        add(0, 1, 0, 1, 3'd3, 59, 0, 2'b00, 2'b01, 0, 1);  // hold blocks trigger
        add(0, 1, 0, 0, 3'd4, 9,  1, 2'b00, 2'b10, 0, 1);  // EW_G -> EW_Y
        add(0, 0, 0, 0, 3'd4, 9,  0, 2'b00, 2'b10, 0, 1);
        add(0, 1, 0, 0, 3'd5, 1,  1, 2'b00, 2'b00, 0, 1);  // EW_Y -> RED_B
        add(0, 0, 0, 0, 3'd5, 1,  0, 2'b00, 2'b00, 0, 1);
        add(0, 1, 0, 0, 3'd6, 29, 1, 2'b00, 2'b00, 1, 0);  // RED_B -> PED, clears pending
        add(0, 0, 1, 0, 3'd6, 29, 0, 2'b00, 2'b00, 1, 0);  // press during PED ignored
        add(0, 1, 0, 0, 3'd0, 59, 1, 2'b01, 2'b00, 0, 0);  // PED -> NS_G via next_dir
        add(0, 1, 0, 0, 3'd0, 59, 0, 2'b01, 2'b00, 0, 0);  // entry-cycle trigger dropped
        add(0, 0, 1, 0, 3'd0, 59, 0, 2'b01, 2'b00, 0, 1);  // request latched
        add(1, 0, 0, 0, 3'd0, 59, 1, 2'b01, 2'b00, 0, 0);  // reset drops request

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst         = vecs[i].rst;
            man_trig    = vecs[i].trig;
            bus.ped_req = vecs[i].req;
            bus.hold    = vecs[i].hold;
            step();
            check($sformatf("vec%0d_phase", i), bus.phase, vecs[i].ph);
            check($sformatf("vec%0d_ref", i), bus.tmr_ref, vecs[i].rf);
            check($sformatf("vec%0d_clear", i), bus.tmr_clear, vecs[i].clr);
            check($sformatf("vec%0d_ns", i), bus.ns_light, vecs[i].ns);
            check($sformatf("vec%0d_ew", i), bus.ew_light, vecs[i].ew);
            check($sformatf("vec%0d_walk", i), bus.walk, vecs[i].walk);
            check($sformatf("vec%0d_pending", i), bus.ped_pending, vecs[i].pend);
        end
        man_trig = 1'b0;

        // ---- normal cycle with model timer: two full rounds ----
        timer_en = 1'b1;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
            exp_q.push_back(3'd4); exp_q.push_back(3'd5); exp_q.push_back(3'd0);
        end
        first = 1'b1;
        prev = 3'd0;
        while (exp_q.size() > 0) begin
            ph = exp_q.pop_front();
            wait_change(ph, dur);
            if (!first) check("dwell_cycles", dur, ref_of(prev) + 2);
            prev = ph;
            first = 1'b0;
        end

        // ---- single pedestrian press during NS_G ----
        do_reset();
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        check("ped_latched", bus.ped_pending, 1);
        wait_change(3'd1, dur);
        wait_change(3'd2, dur);
        wait_change(3'd6, dur);
        check("ped_walk", bus.walk, 1);
        check("ped_pending_cleared", bus.ped_pending, 0);
        wait_change(3'd3, dur);
        check("ped_dwell", dur, 29 + 2);
        check("ped_walk_off", bus.walk, 0);
        check("ped_pending_after", bus.ped_pending, 0);

        // ---- request held through PED: served once, re-latched after ----
        do_reset();
        bus.ped_req = 1'b1;
        wait_change(3'd1, dur);
        wait_change(3'd2, dur);
        wait_change(3'd6, dur);
        check("held_pending_in_ped", bus.ped_pending, 0);
        wait_change(3'd3, dur);
        check("held_pending_at_exit", bus.ped_pending, 0);
        step();
        check("held_relatched", bus.ped_pending, 1);
        bus.ped_req = 1'b0;
        wait_change(3'd4, dur);
        wait_change(3'd5, dur);
        wait_change(3'd6, dur);
        check("second_ped_walk", bus.walk, 1);
        wait_change(3'd0, dur);
        check("second_ped_ns", bus.ns_light, 1);

        // ---- hold during EW_Y with trigger pulsing ----
        do_reset();
        wait_change(3'd1, dur);
        wait_change(3'd2, dur);
        wait_change(3'd3, dur);
        wait_change(3'd4, dur);
        timer_en = 1'b0;
        man_trig = 1'b0;
        bus.hold = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            man_trig = ((i % 5) == 2);
            step();
            if (bus.phase != 3'd4 || bus.ew_light != 2'b10 || bus.tmr_ref != 7'd9) bad++;
        end
        check("hold_frozen_cycles_bad", bad, 0);
        bus.hold = 1'b0;
        man_trig = 1'b0;
        step();
        check("hold_release_idle", bus.phase, 4);
        man_trig = 1'b1;
        step();
        man_trig = 1'b0;
        check("hold_release_phase", bus.phase, 5);
        check("hold_release_ew", bus.ew_light, 0);
        check("hold_release_ref", bus.tmr_ref, 1);
        check("hold_release_clear", bus.tmr_clear, 1);

        // ---- reset while in PED ----
        timer_en = 1'b1;
        do_reset();
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        wait_change(3'd1, dur);
        wait_change(3'd2, dur);
        wait_change(3'd6, dur);
        timer_en = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("rst_ped_phase", bus.phase, 0);
        check("rst_ped_ns", bus.ns_light, 1);
        check("rst_ped_walk", bus.walk, 0);
        check("rst_ped_clear", bus.tmr_clear, 1);
        check("rst_ped_ref", bus.tmr_ref, 59);
        rst = 1'b0;
        step();
        check("rst_clear_drops", bus.tmr_clear, 0);

        // ---- illegal state code recovers to NS_G ----
        force dut.state = ST_BAD;
        #1;
        check("illegal_phase_seen", bus.phase, 7);
        step();
        check("illegal_recover_clear", bus.tmr_clear, 1);
        check("illegal_recover_ns", bus.ns_light, 1);
        check("illegal_recover_ref", bus.tmr_ref, 59);
        release dut.state;
        step();
        check("illegal_recover_phase", bus.phase, 0);

        // ---- final report ----
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
